// File: rtl/jtdsp16_cache_ctrl_if.sv
// Bus between the DSP16 fetch/decode path and the loop-cache sequencer.
interface jtdsp16_cache_ctrl_if #(
    parameter int unsigned AW = 4,
    parameter int unsigned KW = 7
);
    logic          cen;
    logic          do_start;
    logic          redo_start;
    logic [AW-1:0] do_n;
    logic [KW-1:0] do_k;
    logic          fetch_vld;
    logic [15:0]   rom_dout;
    logic [15:0]   cache_dout;
    logic          cache_sel;
    logic          pc_halt;
    logic          busy;
    logic          done;
    logic          cache_valid;

    modport master (
        output cen, do_start, redo_start, do_n, do_k, fetch_vld, rom_dout,
        input  cache_dout, cache_sel, pc_halt, busy, done, cache_valid
    );

    modport slave (
        input  cen, do_start, redo_start, do_n, do_k, fetch_vld, rom_dout,
        output cache_dout, cache_sel, pc_halt, busy, done, cache_valid
    );
endinterface

// File: rtl/jtdsp16_cache_ctrl.sv
// Loop-cache sequencer for DSP16 "do K { N }" / "redo K": captures the body on the first
// pass, then replays it from the cache. Define JTDSP16_REDO_EN to enable the redo path.
module jtdsp16_cache_ctrl #(
    parameter int unsigned AW = 4,
    parameter int unsigned KW = 7
) (
    input  logic                 clk,
    input  logic                 rst_n,
    jtdsp16_cache_ctrl_if.slave  bus
);
    localparam int unsigned DEPTH = 1 << AW;

    typedef enum logic [1:0] {IDLE, FILL, REPLAY} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] n, n_nxt;
    logic [AW-1:0] wr_ptr, wr_ptr_nxt;
    logic [AW-1:0] rd_ptr, rd_ptr_nxt;
    logic [KW-1:0] rem, rem_nxt;
    logic          done_r, done_nxt;
    logic          valid_r, valid_nxt;
    logic          mem_we;
    logic [15:0]   mem [DEPTH];

    // Next-state logic; evaluated as if cen=1, the register stage applies the enable.
    always_comb begin
        state_nxt  = state;
        n_nxt      = n;
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        rem_nxt    = rem;
        done_nxt   = 1'b0;
        valid_nxt  = valid_r;
        mem_we     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.do_start && bus.do_n != '0) begin
                    n_nxt      = bus.do_n;
                    rem_nxt    = (bus.do_k < KW'(2)) ? '0 : bus.do_k - KW'(1);
                    wr_ptr_nxt = '0;
                    valid_nxt  = 1'b0;
                    state_nxt  = FILL;
                end
`ifdef JTDSP16_REDO_EN
                else if (bus.redo_start && valid_r && bus.do_k != '0) begin
                    rem_nxt    = bus.do_k;
                    rd_ptr_nxt = '0;
                    state_nxt  = REPLAY;
                end
`endif
            end
            FILL: begin
                if (bus.fetch_vld) begin
                    mem_we     = 1'b1;
                    wr_ptr_nxt = wr_ptr + AW'(1);
                    if (wr_ptr == n - AW'(1)) begin
                        valid_nxt  = 1'b1;
                        rd_ptr_nxt = '0;
                        if (rem == '0) begin
                            state_nxt = IDLE;
                            done_nxt  = 1'b1;
                        end else begin
                            state_nxt = REPLAY;
                        end
                    end
                end
            end
            REPLAY: begin
                // Pointer wraps at the body length; each wrap consumes one pass.
                if (rd_ptr == n - AW'(1)) begin
                    rd_ptr_nxt = '0;
                    rem_nxt    = rem - KW'(1);
                    if (rem == KW'(1)) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end else begin
                    rd_ptr_nxt = rd_ptr + AW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            n       <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            rem     <= '0;
            done_r  <= 1'b0;
            valid_r <= 1'b0;
        end else if (bus.cen) begin
            state   <= state_nxt;
            n       <= n_nxt;
            wr_ptr  <= wr_ptr_nxt;
            rd_ptr  <= rd_ptr_nxt;
            rem     <= rem_nxt;
            done_r  <= done_nxt;
            valid_r <= valid_nxt;
        end
    end

    // Body storage; contents survive reset.
    always_ff @(posedge clk) begin
        if (rst_n && bus.cen && mem_we) mem[wr_ptr] <= bus.rom_dout;
    end

    assign bus.cache_sel  = (state == REPLAY);
    assign bus.pc_halt    = (state == REPLAY);
    assign bus.busy       = (state != IDLE);
    assign bus.done       = done_r;
    assign bus.cache_dout = (state == REPLAY) ? mem[rd_ptr] : 16'h0;

`ifdef JTDSP16_REDO_EN
    assign bus.cache_valid = valid_r;
`else
    logic unused_redo;
    assign unused_redo     = bus.redo_start;
    assign bus.cache_valid = 1'b0;
`endif
endmodule

// File: tb/tb_jtdsp16_cache_ctrl.sv
// Randomized bench for jtdsp16_cache_ctrl: each loop is scripted from the do/redo rules
// (fill N words, replay the body K-1 or K times, one done pulse) and compared per cycle.
module tb_jtdsp16_cache_ctrl;
    localparam int unsigned AW = 4;
    localparam int unsigned KW = 7;
`ifdef JTDSP16_REDO_EN
    localparam bit REDO = 1'b1;
`else
    localparam bit REDO = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    jtdsp16_cache_ctrl_if #(.AW(AW), .KW(KW)) bus ();
    jtdsp16_cache_ctrl #(.AW(AW), .KW(KW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cen_mode = 0;
    bit          cache_ok = 1'b0;
    int          cached_n = 0;
    logic [15:0] body[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input bit sel, input bit bsy, input bit dn,
                              input bit vld, input logic [15:0] dout, input bit chk_dout);
        check({tag, ".sel"},   32'(bus.cache_sel),   32'(sel));
        check({tag, ".halt"},  32'(bus.pc_halt),     32'(sel));
        check({tag, ".busy"},  32'(bus.busy),        32'(bsy));
        check({tag, ".done"},  32'(bus.done),        32'(dn));
        check({tag, ".valid"}, 32'(bus.cache_valid), 32'(vld));
        if (chk_dout) check({tag, ".dout"}, 32'(bus.cache_dout), 32'(dout));
    endtask

    function automatic logic pick_cen();
        case (cen_mode)
            0:       return 1'b1;
            1:       return ~bus.cen;
            default: return 1'($urandom % 2);
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        bus.do_start   = 1'b0;
        bus.redo_start = 1'b0;
        bus.fetch_vld  = 1'b0;
    endtask

    // Start requests while busy must be ignored.
    task automatic noise();
        bus.do_start   = ($urandom % 6 == 0);
        bus.redo_start = ($urandom % 6 == 0);
        bus.do_n       = AW'($urandom);
        bus.do_k       = KW'($urandom);
    endtask

    task automatic do_reset(input string tag);
        quiet();
        bus.cen = 1'b0;
        rst_n   = 1'b0;
        tick();
        rst_n    = 1'b1;
        cache_ok = 1'b0;
        check_outs(tag, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    endtask

    task automatic replay(input int passes, input int n, input int rst_at, input string tag,
                          output bit aborted);
        int steps = 0;
        aborted = 1'b0;
        for (int p = 0; p < passes; p++) begin
            for (int i = 0; i < n; i++) begin
                int guard = 0;
                forever begin
                    if (steps == rst_at) begin
                        do_reset({tag, ".rst"});
                        aborted = 1'b1;
                        return;
                    end
                    bus.cen = pick_cen();
                    if (guard > 4) bus.cen = 1'b1;
                    noise();
                    bus.fetch_vld = 1'($urandom);
                    bus.rom_dout  = 16'($urandom);
                    check_outs({tag, ".rep"}, 1'b1, 1'b1, 1'b0, REDO & cache_ok, body[i], 1'b1);
                    tick();
                    guard++;
                    if (bus.cen) break;
                end
                steps++;
            end
        end
    endtask

    task automatic expect_done(input string tag);
        quiet();
        check_outs({tag, ".end"}, 1'b0, 1'b0, 1'b1, REDO & cache_ok, 16'h0, 1'b1);
        bus.cen = 1'b0;
        tick();
        check_outs({tag, ".hold"}, 1'b0, 1'b0, 1'b1, REDO & cache_ok, 16'h0, 1'b0);
        bus.cen = 1'b1;
        tick();
        check_outs({tag, ".idle"}, 1'b0, 1'b0, 1'b0, REDO & cache_ok, 16'h0, 1'b0);
    endtask

    task automatic run_do(input int n, input int k, input bit with_redo, input int rst_at);
        string tag = $sformatf("do_n%0d_k%0d", n, k);
        int    w = 0;
        int    guard = 0;
        bit    aborted = 1'b0;
        body.delete();
        for (int i = 0; i < n; i++) body.push_back(16'($urandom));
        bus.cen        = 1'b1;
        bus.do_start   = 1'b1;
        bus.redo_start = with_redo;
        bus.do_n       = AW'(n);
        bus.do_k       = KW'(k);
        bus.fetch_vld  = 1'b0;
        tick();
        cache_ok = 1'b0;
        while (w < n && guard < 1000) begin
            bus.cen = pick_cen();
            noise();
            bus.fetch_vld = ($urandom % 4 != 0);
            bus.rom_dout  = bus.fetch_vld ? body[w] : 16'($urandom);
            check_outs({tag, ".fill"}, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
            tick();
            if (bus.cen && bus.fetch_vld) w++;
            guard++;
        end
        check({tag, ".fill_words"}, 32'(w), 32'(n));
        cache_ok = 1'b1;
        cached_n = n;
        if (k >= 2) replay(k - 1, n, rst_at, tag, aborted);
        if (!aborted) expect_done(tag);
    endtask

    task automatic run_redo(input int k, input string tag);
        bit aborted;
        bus.cen        = 1'b1;
        bus.do_start   = 1'b0;
        bus.redo_start = 1'b1;
        bus.do_n       = AW'($urandom);
        bus.do_k       = KW'(k);
        bus.fetch_vld  = 1'b0;
        tick();
        quiet();
        if (REDO && cache_ok && k > 0) begin
            replay(k, cached_n, -1, tag, aborted);
            expect_done(tag);
        end else begin
            check_outs({tag, ".ign"}, 1'b0, 1'b0, 1'b0, REDO & cache_ok, 16'h0, 1'b1);
        end
    endtask

    initial begin
        bus.cen      = 1'b0;
        bus.do_n     = '0;
        bus.do_k     = '0;
        bus.rom_dout = '0;
        quiet();
        rst_n = 1'b0;
        do_reset("reset");
        run_redo(2, "redo_empty");

        bus.cen      = 1'b1;
        bus.do_start = 1'b1;
        bus.do_n     = '0;
        bus.do_k     = KW'(5);
        tick();
        quiet();
        check_outs("do_n0", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);

        run_do(3, 4, 1'b0, -1);
        run_redo(2, "redo_k2");
        run_redo(0, "redo_k0");
        run_do(3, 1, 1'b0, -1);
        run_redo(1, "redo_k1");
        cen_mode = 1;
        run_do(3, 4, 1'b0, -1);
        cen_mode = 0;
        run_do(3, 4, 1'b0, 4);
        run_redo(2, "redo_after_rst");
        run_do(1, 2, 1'b1, -1);
        run_do(15, 3, 1'b0, -1);
        run_do(4, 0, 1'b0, -1);
        run_do(2, 127, 1'b0, -1);

        cen_mode = 2;
        for (int t = 0; t < 30; t++) begin
            if ($urandom % 4 == 0) run_redo(int'($urandom % 5), "rnd_redo");
            else run_do(int'($urandom_range(1, 15)), int'($urandom_range(0, 8)),
                        1'($urandom % 2), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
